// File: rtl/audio_pkg.sv
// Shared types and constants for the tune player.
// State encoding, pitch codes and the octave-4 divider table.
package audio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        NOTE,
        GAP,
        ADV
    } state_t;

    localparam logic [3:0] PITCH_REST = 4'd0;
    localparam logic [3:0] PITCH_END  = 4'd15;

    localparam int DUR_UNIT = 4;

    // C4..B4 dividers for clk/(256*(div+1))
    localparam logic [11:0] BASE_DIV [0:11] = '{
        12'd746, 12'd704, 12'd664, 12'd627,
        12'd592, 12'd558, 12'd527, 12'd497,
        12'd469, 12'd443, 12'd418, 12'd394
    };

endpackage

// File: rtl/tempo_prescaler.sv
// Tempo prescaler: divides clk down to a one-cycle tick.
// Counts only while run is high; clear restarts the period.
module tempo_prescaler #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = run && w_last;

    // Period counter, wraps on the tick cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run) begin
            if (w_last) r_cnt <= '0;
            else        r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Song player feeding the PWM sine generator.
// Walks the song ROM, driving divider and gate per entry.
module note_sequencer
    import audio_pkg::*;
#(
    parameter int TICK_DIV  = 500000,
    parameter int GAP_TICKS = 1,
    parameter int SONG_LEN  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [1:0]  octave,
    output logic [11:0] divider,
    output logic        gate,
    output logic        busy,
    output logic [3:0]  note_idx
);

    localparam logic [3:0] LAST_IDX = 4'(SONG_LEN - 1);
    localparam logic [7:0] GAP_CNT  = 8'(GAP_TICKS);
    localparam bit         HAS_GAP  = (GAP_TICKS > 0);

    function automatic logic [7:0] song_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    song_rom = 8'hA0;
            4'd1:    song_rom = 8'h00;
            4'd2:    song_rom = 8'h11;
            default: song_rom = 8'hF0;
        endcase
    endfunction

    function automatic logic [11:0] pitch_base(input logic [3:0] code);
        case (code)
            4'd1:    pitch_base = BASE_DIV[0];
            4'd2:    pitch_base = BASE_DIV[1];
            4'd3:    pitch_base = BASE_DIV[2];
            4'd4:    pitch_base = BASE_DIV[3];
            4'd5:    pitch_base = BASE_DIV[4];
            4'd6:    pitch_base = BASE_DIV[5];
            4'd7:    pitch_base = BASE_DIV[6];
            4'd8:    pitch_base = BASE_DIV[7];
            4'd9:    pitch_base = BASE_DIV[8];
            4'd10:   pitch_base = BASE_DIV[9];
            4'd11:   pitch_base = BASE_DIV[10];
            4'd12:   pitch_base = BASE_DIV[11];
            default: pitch_base = 12'd0;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_div;
    logic        r_gate;
    logic [3:0]  r_idx;
    logic [7:0]  r_cnt;

    logic [7:0]  w_entry;
    logic [3:0]  w_code;
    logic [3:0]  w_dur;
    logic        w_end;
    logic        w_is_note;
    logic [7:0]  w_len;
    logic        w_tick;
    logic        w_run;
    logic        w_clear;
    logic        w_busy;
    logic        w_last;

    assign w_entry   = song_rom(r_idx);
    assign w_code    = w_entry[7:4];
    assign w_dur     = w_entry[3:0];
    assign w_end     = (w_code == PITCH_END);
    assign w_is_note = (w_code != PITCH_REST) && (w_code <= 4'd12);
    assign w_len     = 8'(({4'd0, w_dur} + 8'd1) * DUR_UNIT);
    assign w_last    = w_tick && (r_cnt == 8'd1);

    tempo_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .run   (w_run),
        .tick  (w_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; stop overrides every transition
    always_comb begin
        w_next = r_state;
        if (stop) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: if (start) w_next = LOAD;
                LOAD: begin
                    if (!w_end)        w_next = NOTE;
                    else if (!loop_en) w_next = IDLE;
                end
                NOTE: if (w_last) w_next = HAS_GAP ? GAP : ADV;
                GAP:  if (w_last) w_next = ADV;
                ADV: begin
                    if (r_idx == LAST_IDX && !loop_en) w_next = IDLE;
                    else                               w_next = LOAD;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Per-state outputs and prescaler control
    always_comb begin
        w_busy  = (r_state != IDLE);
        w_run   = (r_state == NOTE) || (r_state == GAP);
        w_clear = (r_state == LOAD);
    end

    // Pitch, gate, song index and tick countdown
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_gate <= 1'b0;
            r_idx  <= '0;
            r_cnt  <= '0;
        end else if (stop) begin
            r_gate <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (start) r_idx <= '0;
                LOAD: begin
                    if (w_end) begin
                        if (loop_en) r_idx <= '0;
                    end else begin
                        r_cnt  <= w_len;
                        r_gate <= w_is_note;
                        if (w_is_note)
                            r_div <= pitch_base(w_code) >> octave;
                    end
                end
                NOTE: begin
                    if (w_last) begin
                        r_gate <= 1'b0;
                        r_cnt  <= GAP_CNT;
                    end else if (w_tick) begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                GAP: if (w_tick) r_cnt <= r_cnt - 8'd1;
                ADV: begin
                    if (r_idx != LAST_IDX) r_idx <= r_idx + 4'd1;
                    else if (loop_en)      r_idx <= '0;
                end
                default: r_gate <= 1'b0;
            endcase
        end
    end

    assign divider  = r_div;
    assign gate     = r_gate;
    assign busy     = w_busy;
    assign note_idx = r_idx;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer (TICK_DIV=4, GAP_TICKS=1).
// Expected per-cycle outputs are hand-derived segment lengths.
module tb_note_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [1:0]  octave;
    logic [11:0] divider;
    logic        gate;
    logic        busy;
    logic [3:0]  note_idx;

    int n_checks;
    int n_errors;

    note_sequencer #(
        .TICK_DIV  (4),
        .GAP_TICKS (1),
        .SONG_LEN  (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .octave   (octave),
        .divider  (divider),
        .gate     (gate),
        .busy     (busy),
        .note_idx (note_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check all outputs for n cycles, advancing one clock each.
    task automatic seg(input string tag, input int n, input logic g,
                       input logic b, input logic [3:0] idx,
                       input logic [11:0] d);
        for (int i = 0; i < n; i++) begin
            chk({tag, ".gate"}, 32'(gate), 32'(g));
            chk({tag, ".busy"}, 32'(busy), 32'(b));
            chk({tag, ".idx"}, 32'(note_idx), 32'(idx));
            chk({tag, ".div"}, 32'(divider), 32'(d));
            step();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        loop_en  = 1'b0;
        octave   = 2'd0;
        step();
        step();
        rst_n = 1'b1;
        seg("reset", 2, 1'b0, 1'b0, 4'd0, 12'd0);

        // Single pass, no loop
        start = 1'b1;
        step();
        start = 1'b0;
        seg("p1.load0", 1, 1'b0, 1'b1, 4'd0, 12'd0);
        seg("p1.a4", 16, 1'b1, 1'b1, 4'd0, 12'd443);
        seg("p1.gap0", 5, 1'b0, 1'b1, 4'd0, 12'd443);
        seg("p1.rest", 22, 1'b0, 1'b1, 4'd1, 12'd443);
        seg("p1.load2", 1, 1'b0, 1'b1, 4'd2, 12'd443);
        seg("p1.c4", 32, 1'b1, 1'b1, 4'd2, 12'd746);
        seg("p1.gap2", 5, 1'b0, 1'b1, 4'd2, 12'd746);
        seg("p1.end", 1, 1'b0, 1'b1, 4'd3, 12'd746);
        seg("p1.idle", 3, 1'b0, 1'b0, 4'd3, 12'd746);

        // Looping, two octaves up
        loop_en = 1'b1;
        octave  = 2'd2;
        start   = 1'b1;
        step();
        start = 1'b0;
        seg("p2.load0", 1, 1'b0, 1'b1, 4'd0, 12'd746);
        seg("p2.a6", 16, 1'b1, 1'b1, 4'd0, 12'd110);
        seg("p2.gap0", 5, 1'b0, 1'b1, 4'd0, 12'd110);
        seg("p2.rest", 22, 1'b0, 1'b1, 4'd1, 12'd110);
        seg("p2.load2", 1, 1'b0, 1'b1, 4'd2, 12'd110);
        seg("p2.c6", 32, 1'b1, 1'b1, 4'd2, 12'd186);
        seg("p2.gap2", 5, 1'b0, 1'b1, 4'd2, 12'd186);
        seg("p2.end", 1, 1'b0, 1'b1, 4'd3, 12'd186);
        seg("p2.wrap", 1, 1'b0, 1'b1, 4'd0, 12'd186);
        seg("p2.a6b", 16, 1'b1, 1'b1, 4'd0, 12'd110);
        seg("p2.gap0b", 5, 1'b0, 1'b1, 4'd0, 12'd110);
        seg("p2.load1b", 1, 1'b0, 1'b1, 4'd1, 12'd110);

        // start while busy must not disturb timing
        seg("p3.rest", 5, 1'b0, 1'b1, 4'd1, 12'd110);
        start = 1'b1;
        seg("p3.busy_start", 1, 1'b0, 1'b1, 4'd1, 12'd110);
        start = 1'b0;
        seg("p3.rest2", 15, 1'b0, 1'b1, 4'd1, 12'd110);
        seg("p3.load2", 1, 1'b0, 1'b1, 4'd2, 12'd110);
        seg("p3.c6", 10, 1'b1, 1'b1, 4'd2, 12'd186);

        // stop mid-note, with a simultaneous start
        stop  = 1'b1;
        start = 1'b1;
        seg("p3.stop_edge", 1, 1'b1, 1'b1, 4'd2, 12'd186);
        stop  = 1'b0;
        start = 1'b0;
        seg("p3.stopped", 3, 1'b0, 1'b0, 4'd2, 12'd186);

        // Reset in the middle of a gap
        loop_en = 1'b0;
        octave  = 2'd0;
        start   = 1'b1;
        step();
        start = 1'b0;
        seg("p4.load0", 1, 1'b0, 1'b1, 4'd0, 12'd186);
        seg("p4.a4", 16, 1'b1, 1'b1, 4'd0, 12'd443);
        seg("p4.gap0", 5, 1'b0, 1'b1, 4'd0, 12'd443);
        seg("p4.rest", 22, 1'b0, 1'b1, 4'd1, 12'd443);
        seg("p4.load2", 1, 1'b0, 1'b1, 4'd2, 12'd443);
        seg("p4.c4", 32, 1'b1, 1'b1, 4'd2, 12'd746);
        seg("p4.gap2", 2, 1'b0, 1'b1, 4'd2, 12'd746);
        rst_n = 1'b0;
        step();
        seg("p4.in_reset", 1, 1'b0, 1'b0, 4'd0, 12'd0);
        rst_n = 1'b1;
        seg("p4.after_reset", 2, 1'b0, 1'b0, 4'd0, 12'd0);

        // stop beats start while idle
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        seg("p5.stop_wins", 3, 1'b0, 1'b0, 4'd0, 12'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Tune player that sits directly upstream of the PWM sine generator.
- Steps through an internal song ROM and, for each entry, drives the sine generator's 12-bit `divider` with the note pitch and a `gate` that mutes the note during rests and articulation gaps.
- Note timing derives from a tempo prescaler on `clk`; pitch comes from a 12-entry semitone table with an octave shift.

Parameters:
- TICK_DIV, 500000: clk cycles per tempo tick (10 ms at 50 MHz); min 2.
- GAP_TICKS, 1: silent ticks after every note or rest; 0 disables the GAP state.
- SONG_LEN, 16: number of song ROM entries; the index wraps after SONG_LEN-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  pulse; begin playback from index 0 (honoured only in IDLE)
- stop  in  1  pulse; abort playback
- loop_en  in  1  on END marker or index wrap: 1 = restart at index 0, 0 = go IDLE
- octave  in  2  right-shift applied to the base divider (0 = octave 4, 3 = octave 7)
- divider  out  12  to sine generator; output freq = clk/(256*(divider+1))
- gate  out  1  1 = note sounding; consumer mutes when 0
- busy  out  1  1 in any state except IDLE
- note_idx  out  4  current ROM index

Behaviour:
- Reset values: state IDLE, divider 0, gate 0, busy 0, note_idx 0, prescaler 0, tick counter 0.
- ROM entry is 8 bits: [7:4] pitch code, [3:0] duration field d. Note length is (d+1)*4 ticks.
- Pitch codes:
  - 0: rest; gate 0, divider holds its previous value.
  - 1..12: C4..B4 base dividers 746, 704, 664, 627, 592, 558, 527, 497, 469, 443, 418, 394.
  - 13, 14: treated as rest.
  - 15: END marker.
- divider = base >> octave, with octave sampled in LOAD.
- Default song:
  - idx0 = 0xA0 (A4, 4 ticks)
  - idx1 = 0x00 (rest, 4 ticks)
  - idx2 = 0x11 (C4, 8 ticks)
  - idx3..15 = 0xF0 (END)
- States:
  - IDLE: gate 0. start=1 and stop=0 → note_idx←0, go LOAD.
  - LOAD (1 cycle): prescaler←0. Decode ROM[note_idx].
    - END → if loop_en: note_idx←0, stay LOAD; else go IDLE.
    - Otherwise load divider/gate, tick counter←(d+1)*4, go NOTE.
  - NOTE: on each tick, decrement the counter; when it reaches 0, gate←0 and go GAP (or go ADV if GAP_TICKS=0).
  - GAP: gate 0; after GAP_TICKS ticks go ADV.
  - ADV (1 cycle):
    - note_idx==SONG_LEN-1 → if loop_en: note_idx←0, go LOAD; else go IDLE.
    - Otherwise note_idx+1, go LOAD.
- Tick: the prescaler counts 0..TICK_DIV-1 in NOTE/GAP and pulses when it reaches TICK_DIV-1, then wraps to 0. The first tick therefore comes TICK_DIV cycles after LOAD.
- Latency: start sampled at edge N → LOAD during N+1 → divider/gate valid from N+2.
- stop=1 in any state → IDLE next cycle, gate 0, divider held. stop wins over a simultaneous start.
- start while busy: ignored.
- loop_en is sampled only at END/wrap decisions.
- Synchronous reset mid-playback returns everything to reset values on the next edge.

Decomposition:
- Shared package `audio_pkg`:
  - state enum (IDLE, LOAD, NOTE, GAP, ADV)
  - pitch code constants (PITCH_REST=0, PITCH_END=15)
  - base divider table constant
  - DUR_UNIT=4
- One natural sub-module: `tempo_prescaler`, with inputs clk/rst_n/clear/run and a single-cycle `tick` output.
- The song ROM and pitch table are case functions inside note_sequencer.

Test Plan:
All scenarios use TICK_DIV=4, GAP_TICKS=1, default song.
1. Reset, then start pulse at cycle 0 → LOAD at 1; divider=443, gate=1, busy=1 from cycle 2; gate high for exactly 16 cycles, then low 4 (GAP), then 1 ADV cycle and 1 LOAD cycle.
2. Continue scenario 1 → idx1 rest: gate 0 for 20 cycles, divider stays 443. Then idx2: divider=746, gate=1 for 32 cycles. Then END with loop_en=0 → IDLE, busy=0.
3. loop_en=1, octave=2 → idx0 divider=110 (443>>2). After END, note_idx returns to 0 and the sequence repeats indefinitely.
4. stop asserted mid-NOTE of idx2 → next cycle IDLE, gate=0, busy=0, divider stays 746. A start in the same cycle as stop is ignored.
5. start pulsed while busy → no effect on note_idx or timing. Reset asserted mid-GAP → divider=0, note_idx=0, IDLE on the next edge.
